// File: rtl/hex_msg_pkg.sv
// Shared types and constant tables for the hex message display.
// Contents:
//   char_t      5-bit character code rendered by char_to_seg
//   msg_id_t    message identifiers selected from game_state/player
//   mode_t      per-message display mode (static, scrolling, blinking)
//   MSG_ROM     character table, one row of ROM_LEN characters per message
//   MSG_LENGTH  real length L of each message (row tail beyond L is unused)
//   MSG_MODE    display mode of each message
//   select_msg  maps game_state/player onto a message id
package hex_msg_pkg;

  localparam int ROM_LEN  = 16;
  localparam int NUM_MSGS = 8;

  typedef enum logic [4:0] {
    C_BLANK = 5'd0, C_G, C_O, C_R, C_E, C_D, C_N, C_ONE,
    C_F, C_U, C_L, C_P, C_S, C_T, C_DASH
  } char_t;

  typedef enum logic [2:0] {
    GO_RED = 3'd0, GO_GRN, RED_WIN, GRN_WIN, TIE
  } msg_id_t;

  typedef enum logic [1:0] {STATIC, SCROLL, BLINK} mode_t;

  // Rows 5..7 are never selected; they exist so any 3-bit id indexes safely.
  localparam char_t MSG_ROM [NUM_MSGS][ROM_LEN] = '{
    '{C_G, C_O, C_BLANK, C_R, C_E, C_D, C_BLANK, C_BLANK,
      C_BLANK, C_BLANK, C_BLANK, C_BLANK, C_BLANK, C_BLANK, C_BLANK, C_BLANK},
    '{C_G, C_O, C_BLANK, C_G, C_R, C_N, C_BLANK, C_BLANK,
      C_BLANK, C_BLANK, C_BLANK, C_BLANK, C_BLANK, C_BLANK, C_BLANK, C_BLANK},
    '{C_R, C_E, C_D, C_BLANK, C_ONE, C_BLANK, C_BLANK, C_P,
      C_R, C_E, C_S, C_S, C_BLANK, C_R, C_S, C_T},
    '{C_G, C_R, C_N, C_BLANK, C_ONE, C_BLANK, C_BLANK, C_P,
      C_R, C_E, C_S, C_S, C_BLANK, C_R, C_S, C_T},
    '{C_F, C_U, C_L, C_L, C_BLANK, C_BLANK, C_BLANK, C_BLANK,
      C_BLANK, C_BLANK, C_BLANK, C_BLANK, C_BLANK, C_BLANK, C_BLANK, C_BLANK},
    '{default: C_BLANK},
    '{default: C_BLANK},
    '{default: C_BLANK}
  };

  localparam logic [4:0] MSG_LENGTH [NUM_MSGS] = '{
    5'd6, 5'd6, 5'd16, 5'd16, 5'd4, 5'd0, 5'd0, 5'd0
  };

  localparam mode_t MSG_MODE [NUM_MSGS] = '{
    STATIC, STATIC, SCROLL, SCROLL, BLINK, STATIC, STATIC, STATIC
  };

  function automatic msg_id_t select_msg(input logic [1:0] gs, input logic pl);
    case (gs)
      2'b00:   return pl ? GO_GRN : GO_RED;
      2'b01:   return RED_WIN;
      2'b10:   return GRN_WIN;
      default: return TIE;
    endcase
  endfunction

endpackage

// File: rtl/char_to_seg.sv
// Character code to seven-segment glyph decoder (pure combinational).
// Ports:
//   ch   in  char_t      character code
//   seg  out [6:0]       active-low segments, bit0 = a ... bit6 = g
// Codes without a glyph render as blank.
module char_to_seg
  import hex_msg_pkg::*;
(
  input  char_t      ch,
  output logic [6:0] seg
);

  always_comb begin
    case (ch)
      C_G:     seg = 7'b0000010;
      C_O:     seg = 7'b1000000;
      C_R:     seg = 7'b0101111;
      C_E:     seg = 7'b0000110;
      C_D:     seg = 7'b0100001;
      C_N:     seg = 7'b0101011;
      C_ONE:   seg = 7'b1111001;
      C_F:     seg = 7'b0001110;
      C_U:     seg = 7'b1000001;
      C_L:     seg = 7'b1000111;
      C_P:     seg = 7'b0001100;
      C_S:     seg = 7'b0010010;
      C_T:     seg = 7'b0000111;
      C_DASH:  seg = 7'b0111111;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/hex_message_display.sv
// Game-status message display for NUM_DIGITS seven-segment digits.
// Picks a message from game_state/player, shows short messages statically,
// scrolls long ones left one character per SCROLL_TICKS cycles, and blinks
// the tie message with a BLINK_TICKS half-period.
// Ports:
//   clock        in   system clock, all state on posedge
//   reset        in   synchronous, active-low
//   player       in   0 = red to move, 1 = green to move
//   game_state   in   00 in progress, 01 red wins, 10 green wins, 11 tie
//   freeze       in   holds scroll offset, blink phase and tick counters
//   HEX          out  registered active-low glyphs, HEX[NUM_DIGITS-1] leftmost
//   scroll_wrap  out  one-cycle pulse when the scroll offset wraps to 0
module hex_message_display
  import hex_msg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int MSG_LEN      = 16,
  parameter int SCROLL_TICKS = 25000000,
  parameter int BLINK_TICKS  = 12500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       player,
  input  logic [1:0] game_state,
  input  logic       freeze,
  output logic [6:0] HEX [NUM_DIGITS],
  output logic       scroll_wrap
);

  localparam int OFF_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int SC_W  = $clog2(SCROLL_TICKS);
  localparam int BC_W  = $clog2(BLINK_TICKS);

  msg_id_t          msg_id, cur_id, sel_id;
  logic [OFF_W-1:0] offset, sel_off;
  logic [SC_W-1:0]  scroll_cnt;
  logic [BC_W-1:0]  blink_cnt;
  logic             blink_on, sel_blink;
  logic             scroll_en, blink_en, last_char, msg_change;
  char_t            win_char [NUM_DIGITS];
  logic [6:0]       seg [NUM_DIGITS];

  // Character shown at window position i (0 = leftmost). Positions past the
  // end of a short message are blank; long messages wrap modulo their own
  // length, not the ROM row width.
  function automatic char_t window_char(input msg_id_t id,
                                        input logic [OFF_W-1:0] off,
                                        input int i);
    int len;
    int pos;
    len = int'(MSG_LENGTH[id]);
    if (i >= len) return C_BLANK;
    pos = int'(off) + i;
    if (pos >= len) pos = pos - len;
    return MSG_ROM[id][pos[3:0]];
  endfunction

  assign msg_id     = select_msg(game_state, player);
  assign msg_change = (msg_id != cur_id);
  assign scroll_en  = (MSG_MODE[cur_id] == SCROLL) &&
                      (int'(MSG_LENGTH[cur_id]) > NUM_DIGITS);
  assign blink_en   = (MSG_MODE[cur_id] == BLINK);
  assign last_char  = (int'(offset) == int'(MSG_LENGTH[cur_id]) - 1);

  // The glyph register follows the state registers one cycle behind, except
  // on reset or a message change where the new message at offset 0 is shown
  // from the same edge.
  always_comb begin
    sel_id    = cur_id;
    sel_off   = offset;
    sel_blink = blink_on;
    if (!reset) begin
      sel_id    = GO_RED;
      sel_off   = '0;
      sel_blink = 1'b1;
    end else if (msg_change) begin
      sel_id    = msg_id;
      sel_off   = '0;
      sel_blink = 1'b1;
    end
  end

  always_comb begin
    for (int d = 0; d < NUM_DIGITS; d++)
      win_char[d] = window_char(sel_id, sel_off, NUM_DIGITS - 1 - d);
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    char_to_seg u_dec (.ch(win_char[d]), .seg(seg[d]));
  end

  // Position / phase state
  always_ff @(posedge clock) begin
    if (!reset) begin
      cur_id      <= GO_RED;
      offset      <= '0;
      scroll_cnt  <= '0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      scroll_wrap <= 1'b0;
    end else if (msg_change) begin
      cur_id      <= msg_id;
      offset      <= '0;
      scroll_cnt  <= '0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      scroll_wrap <= 1'b0;
    end else begin
      scroll_wrap <= 1'b0;
      if (!freeze) begin
        if (scroll_en) begin
          if (scroll_cnt == SC_W'(SCROLL_TICKS - 1)) begin
            scroll_cnt <= '0;
            if (last_char) begin
              offset      <= '0;
              scroll_wrap <= 1'b1;
            end else begin
              offset <= offset + OFF_W'(1);
            end
          end else begin
            scroll_cnt <= scroll_cnt + SC_W'(1);
          end
        end
        if (blink_en) begin
          if (blink_cnt == BC_W'(BLINK_TICKS - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
          end else begin
            blink_cnt <= blink_cnt + BC_W'(1);
          end
        end
      end
    end
  end

  // Glyph output register
  always_ff @(posedge clock) begin
    for (int d = 0; d < NUM_DIGITS; d++)
      HEX[d] <= sel_blink ? seg[d] : 7'b1111111;
  end

endmodule

// File: tb/tb_hex_message_display.sv
module tb_hex_message_display;

  localparam int ND = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic       player;
  logic [1:0] game_state;
  logic       freeze;
  logic [6:0] HEX [ND];
  logic       scroll_wrap;

  always #5 clock = ~clock;

  hex_message_display #(
    .NUM_DIGITS(ND), .MSG_LEN(16), .SCROLL_TICKS(4), .BLINK_TICKS(3)
  ) dut (
    .clock(clock), .reset(reset), .player(player), .game_state(game_state),
    .freeze(freeze), .HEX(HEX), .scroll_wrap(scroll_wrap)
  );

  typedef struct {
    string       tag;
    logic [41:0] hex;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  localparam string S_GO_R = "GO rEd";
  localparam string S_GO_G = "GO Grn";
  localparam string S_RED  = "rEd 1  PrESS rSt";
  localparam string S_GRN  = "Grn 1  PrESS rSt";
  localparam string S_TIE  = "FULL";

  function automatic logic [6:0] seg_of(input byte c);
    case (c)
      "G":     return 7'b0000010;
      "O":     return 7'b1000000;
      "r":     return 7'b0101111;
      "E":     return 7'b0000110;
      "d":     return 7'b0100001;
      "n":     return 7'b0101011;
      "1":     return 7'b1111001;
      "F":     return 7'b0001110;
      "U":     return 7'b1000001;
      "L":     return 7'b1000111;
      "P":     return 7'b0001100;
      "S":     return 7'b0010010;
      "t":     return 7'b0000111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected six-digit window, leftmost digit in the top 7 bits.
  function automatic logic [41:0] win(input string msg, input int off);
    logic [41:0] r;
    int len;
    len = msg.len();
    r = '1;
    for (int i = 0; i < ND; i++) begin
      if (i < len) r[41 - 7*i -: 7] = seg_of(msg[(off + i) % len]);
    end
    return r;
  endfunction

  // Window offset seen on HEX k edges after a message change (SCROLL_TICKS=4, L=16).
  function automatic int scroll_off(input int k);
    return (k == 0) ? 0 : ((k - 1) / 4) % 16;
  endfunction

  // Tie glyphs k edges after the message change (BLINK_TICKS=3).
  function automatic logic [41:0] tie_exp(input int k);
    if (k == 0 || ((k - 1) / 3) % 2 == 0) return win(S_TIE, 0);
    return '1;
  endfunction

  task automatic expect_cyc(input string tag, input logic [41:0] h, input logic w);
    exp_t e;
    @(posedge clock);
    #1;
    e.tag  = tag;
    e.hex  = h;
    e.wrap = w;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [41:0] act;
      e = sb.pop_front();
      act = {HEX[5], HEX[4], HEX[3], HEX[2], HEX[1], HEX[0]};
      checks++;
      if (act === e.hex) passes++;
      else $display("FAIL %s hex: got %h expected %h", e.tag, act, e.hex);
      checks++;
      if (scroll_wrap === e.wrap) passes++;
      else $display("FAIL %s scroll_wrap: got %b expected %b", e.tag, scroll_wrap, e.wrap);
    end
  end

  initial begin
    reset = 1'b0; player = 1'b0; game_state = 2'b00; freeze = 1'b0;

    // Reset and move display
    expect_cyc("reset0", win(S_GO_R, 0), 1'b0);
    expect_cyc("reset1", win(S_GO_R, 0), 1'b0);
    reset = 1'b1;
    repeat (2) expect_cyc("go_red", win(S_GO_R, 0), 1'b0);
    player = 1'b1;
    repeat (3) expect_cyc("go_grn", win(S_GO_G, 0), 1'b0);

    // Red-win scroll through one full wrap
    game_state = 2'b01;
    for (int k = 0; k <= 68; k++)
      expect_cyc("red_scroll", win(S_RED, scroll_off(k)), (k > 0 && k % 64 == 0));

    // Tie, then reset while blanked
    game_state = 2'b11;
    for (int k = 0; k <= 4; k++) expect_cyc("tie_pre", tie_exp(k), 1'b0);
    reset = 1'b0;
    expect_cyc("reset_blink", win(S_GO_R, 0), 1'b0);
    reset = 1'b1;
    for (int k = 0; k <= 12; k++) expect_cyc("tie_blink", tie_exp(k), 1'b0);

    // Freeze at offset 2, then resume
    game_state = 2'b01;
    for (int k = 0; k <= 9; k++) expect_cyc("pre_freeze", win(S_RED, scroll_off(k)), 1'b0);
    freeze = 1'b1;
    repeat (20) expect_cyc("freeze", win(S_RED, 2), 1'b0);
    freeze = 1'b0;
    for (int k = 10; k <= 21; k++) expect_cyc("post_freeze", win(S_RED, scroll_off(k)), 1'b0);

    // Message change at offset 5
    game_state = 2'b10;
    for (int k = 0; k <= 9; k++) expect_cyc("grn_scroll", win(S_GRN, scroll_off(k)), 1'b0);

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hex_message_display.md
Name: hex_message_display

Overview:
- Parametrised successor to the six-digit game-status display.
- Drives NUM_DIGITS active-low seven-segment digits from a character-coded message ROM, selected by game_state and player.
- Static messages are shown as-is. Messages longer than the display scroll left. The tie message blinks.
- Sits between the game FSM and the board HEX pins; outputs are registered.

Parameters:
- NUM_DIGITS, 6: number of seven-segment digits driven (2..8).
- MSG_LEN, 16: maximum message length in characters; ROM row width.
- SCROLL_TICKS, 25000000: clock cycles per one-character scroll step (≥2).
- BLINK_TICKS, 12500000: clock cycles per blink half-period (≥2).

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  synchronous, active-low; reset==0 at a posedge resets the block.
- player  in  1  0 = red to move, 1 = green to move.
- game_state  in  2  00 in progress, 01 red wins, 10 green wins, 11 tie.
- freeze  in  1  1 holds scroll offset, blink phase and both tick counters.
- HEX  out  7 x NUM_DIGITS  unpacked array; HEX[NUM_DIGITS-1] is the leftmost digit; active-low, bit0 = segment a.
- scroll_wrap  out  1  one-cycle pulse when the scroll offset wraps from L-1 to 0.

Behaviour:
- Message select (combinational msg_id):
  - 00 with player 0: GO_RED "GO rEd", L=6, static.
  - 00 with player 1: GO_GRN "GO Grn", L=6, static.
  - 01: RED_WIN "rEd 1  PrESS rSt", L=16, scroll.
  - 10: GRN_WIN "Grn 1  PrESS rSt", L=16, scroll.
  - 11: TIE "FULL", L=4, blink.
- Padding and positioning:
  - Messages with L<NUM_DIGITS are left-justified, blank-padded on the right.
  - Scroll is enabled only when L>NUM_DIGITS. Otherwise that message is static, offset stays 0 and scroll_wrap never fires.
- Registered state:
  - cur_id: message id, 3 bits.
  - offset: 0..MSG_LEN-1.
  - scroll_cnt: 0..SCROLL_TICKS-1.
  - blink_cnt: 0..BLINK_TICKS-1.
  - blink_on: 1 = visible.
  - HEX.
  - scroll_wrap.
- Message change: if msg_id != cur_id at a posedge, the block loads cur_id<=msg_id and clears offset, scroll_cnt and blink_cnt, and sets blink_on<=1. HEX shows the new message at offset 0 from that edge, so latency is 1 cycle. Message change takes priority over freeze.
- Scrolling:
  - When freeze==0, scroll_cnt counts up each cycle.
  - At SCROLL_TICKS-1, scroll_cnt returns to 0 and offset advances by 1.
  - If offset==L-1, offset goes to 0 instead and scroll_wrap is 1 for that one cycle.
  - Digit i (i = 0 leftmost in character order) shows char[(offset+i) mod L].
  - Wrap is modulo L, never MSG_LEN.
- Blink (TIE only):
  - blink_cnt wraps at BLINK_TICKS-1 and toggles blink_on.
  - While blink_on==0, all digits are 7'b1111111.
  - For non-blink messages, blink_on is held at 1.
- freeze==1: all counters, offset and blink_on hold. HEX still tracks msg_id changes, which reset the position as above.
- HEX is the registered glyph of the current window, so the display updates one cycle after any offset or blink change.
- Reset (reset==0 at posedge), all outputs defined:
  - HEX = "GO rEd" with blanks right for NUM_DIGITS>6; truncated to the leftmost NUM_DIGITS characters if fewer.
  - cur_id=GO_RED, offset=0, both counters 0, blink_on=1, scroll_wrap=0.
- Reset asserted mid-scroll or mid-blink aborts the operation immediately; there is no pending state.
- Unknown character codes render as blank.

Decomposition:
- Package hex_msg_pkg holds:
  - char_t: 5-bit enum of BLANK, G, O, r, E, d, n, ONE, F, U, L, P, S, t, DASH.
  - msg_id_t enum.
  - The message ROM: constant array [msg_id] of MSG_LEN char_t.
  - The message-length constant array.
  - Per-message mode constants: STATIC, SCROLL, BLINK.
- One sub-module, char_to_seg: pure combinational char_t to 7-bit active-low segment decoder, instantiated NUM_DIGITS times.

Test Plan:
All tests use NUM_DIGITS=6, SCROLL_TICKS=4, BLINK_TICKS=3.
1. Reset and move display:
   - Stimulus: reset=0 for 2 cycles, then release; player 0, game_state=00.
   - Required: HEX = G,O,blank,r,E,d = 0000010, 1000000, 1111111, 0101111, 0000110, 0100001.
   - Stimulus: set player=1.
   - Required: next cycle HEX shows "GO Grn"; last digit = 0101011.
2. Red-win scroll:
   - Stimulus: game_state=01.
   - Required: first HEX "rEd 1 ". After 4 cycles the window is "Ed 1  ". After 64 cycles the offset has wrapped to 0 and scroll_wrap is high for exactly 1 cycle.
3. Tie blink:
   - Stimulus: game_state=11.
   - Required: HEX "FULL" plus 2 blanks, for 3 cycles. Then all 1111111 for 3 cycles, then visible again. scroll_wrap stays 0 throughout.
4. Freeze:
   - Stimulus: during red-win scroll at offset 2, set freeze=1 for 20 cycles.
   - Required: HEX is constant. After freeze=0, the next step occurs after the remaining scroll_cnt ticks.
5. Message change mid-scroll:
   - Stimulus: at offset 5, change game_state 01->10.
   - Required: next cycle HEX "Grn 1 ", offset 0, and a full 4 cycles before the next step.
6. Reset mid-blink:
   - Stimulus: reset=0 while blink_on==0.
   - Required: next edge HEX "GO rEd" and blink_on=1.
